// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words for instruction memory.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] len,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err
);

`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CKSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_n;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       shreg;
    logic              err_q;
    logic              start_ok;
    logic              last_word;
    logic              bad_len;
    logic [31:0]       idx_addr;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        csum;
`endif

    assign start_ok  = start && (state == IDLE || state == DONE);
    assign bad_len   = (len == '0) || (len > CAP);
    assign last_word = (word_idx == len_q - ONE);
    assign idx_addr  = {{(29 - ADDR_W){1'b0}}, word_idx, 2'b00};

    assign err      = err_q;
    assign cpu_hold = !(state == DONE && !err_q);

    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = bad_len ? DONE : RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_cnt == 2'd3) state_n = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
                state_n = last_word ? CKSUM : RECV;
`else
                state_n = last_word ? DONE : RECV;
`endif
            end
`ifdef IMEM_LOADER_CKSUM_EN
            CKSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_n = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_n = bad_len ? DONE : RECV;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            err_q     <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state <= state_n;
            if (start_ok) begin
                len_q    <= len;
                word_idx <= '0;
                byte_cnt <= '0;
                err_q    <= (len > CAP);
`ifdef IMEM_LOADER_CKSUM_EN
                csum     <= '0;
`endif
            end
            // Word and address are latched with the 4th byte so WRITE drives them directly
            if (state == RECV && byte_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                shreg    <= {shreg[15:0], byte_in};
`ifdef IMEM_LOADER_CKSUM_EN
                csum     <= csum ^ byte_in;
`endif
                if (byte_cnt == 2'd3) begin
                    mem_wdata <= {shreg, byte_in};
                    mem_addr  <= BASE_ADDR + idx_addr;
                end
            end
            if (state == WRITE) word_idx <= word_idx + ONE;
`ifdef IMEM_LOADER_CKSUM_EN
            if (state == CKSUM && byte_valid) err_q <= (byte_in != csum);
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test of imem_loader with ADDR_W=2 and a non-zero base.
// Covers both builds; checksum cases run only with IMEM_LOADER_CKSUM_EN.
module tb_imem_loader;

    localparam int          ADDR_W = 2;
    localparam logic [31:0] BASE   = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [ADDR_W:0] len = '0;
    logic [7:0]      byte_in = '0;
    logic            byte_valid = 1'b0;
    logic            byte_ready;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            cpu_hold;
    logic            busy;
    logic            done;
    logic            err;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] wq[$];
    logic [7:0]  cs;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always @(posedge clk) if (reset && mem_we) wq.push_back({mem_addr, mem_wdata});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy"}, byte_ready, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, BASE);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic check_wq(input string tag, input int i, input logic [63:0] exp);
        check(tag, (i < wq.size()) ? wq[i] : 64'd0, exp);
    endtask

    // Called just after a negedge; returns at the negedge following the transfer
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            check("ready_timeout", 0, 1);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cs ^= b;
    endtask

    task automatic gap();
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31 - 8*i -: 8]);
            if (gaps && i < 3) gap();
        end
        check("we_latency", mem_we, 1);
        check("rdy_in_write", byte_ready, 0);
    endtask

    task automatic do_start(input logic [ADDR_W:0] l);
        wq.delete();
        cs    = '0;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(cs);
        byte_valid = 1'b0;
`else
        byte_valid = 1'b0;
        @(negedge clk);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: asynchronous reset mid-cycle
        #2 reset = 1'b0;
        #1 check_reset("rst0");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 2: two words back-to-back
        do_start(3'd2);
        check("t2_busy", busy, 1);
        check("t2_hold", cpu_hold, 1);
        check("t2_done", done, 0);
        check("t2_rdy", byte_ready, 1);
        send_word(32'h2401_2020, 1'b0);
        send_word(32'h8C43_0004, 1'b0);
        finish_load();
        check("t2_n", wq.size(), 2);
        check_wq("t2_w0", 0, {BASE, 32'h2401_2020});
        check_wq("t2_w1", 1, {BASE + 32'd4, 32'h8C43_0004});
        check("t2_done_end", done, 1);
        check("t2_hold_end", cpu_hold, 0);
        check("t2_busy_end", busy, 0);
        check("t2_err_end", err, 0);
        check("t2_rdy_end", byte_ready, 0);

        // 3: valid toggling, stray start mid-RECV
        do_start(3'd2);
        send_word(32'h2401_2020, 1'b1);
        send_byte(8'h8C);
        byte_valid = 1'b0;
        len   = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_busy_mid", busy, 1);
        send_byte(8'h43);
        gap();
        send_byte(8'h00);
        gap();
        send_byte(8'h04);
        check("t3_we_latency", mem_we, 1);
        finish_load();
        check("t3_n", wq.size(), 2);
        check_wq("t3_w0", 0, {BASE, 32'h2401_2020});
        check_wq("t3_w1", 1, {BASE + 32'd4, 32'h8C43_0004});
        check("t3_done", done, 1);
        check("t3_hold", cpu_hold, 0);

        // 4: empty, oversize and full-capacity loads
        do_start(3'd0);
        check("t4z_done", done, 1);
        check("t4z_err", err, 0);
        check("t4z_hold", cpu_hold, 0);
        check("t4z_busy", busy, 0);
        @(negedge clk);
        check("t4z_n", wq.size(), 0);
        do_start(3'd5);
        check("t4o_done", done, 1);
        check("t4o_err", err, 1);
        check("t4o_hold", cpu_hold, 1);
        @(negedge clk);
        check("t4o_n", wq.size(), 0);
        do_start(3'd4);
        check("t4f_err_clr", err, 0);
        send_word(32'h0001_0203, 1'b0);
        send_word(32'h0405_0607, 1'b0);
        send_word(32'h0809_0A0B, 1'b0);
        send_word(32'h0C0D_0E0F, 1'b0);
        finish_load();
        check("t4f_n", wq.size(), 4);
        check_wq("t4f_w2", 2, {BASE + 32'd8, 32'h0809_0A0B});
        check_wq("t4f_w3", 3, {BASE + 32'd12, 32'h0C0D_0E0F});
        check("t4f_done", done, 1);
        check("t4f_hold", cpu_hold, 0);

        // 5: reset after 6 bytes of a 3-word load
        do_start(3'd3);
        send_word(32'h1122_3344, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        byte_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset("rst5");
        check("t5_n", wq.size(), 1);
        check_wq("t5_w0", 0, {BASE, 32'h1122_3344});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_n_after", wq.size(), 1);
        do_start(3'd1);
        send_word(32'hDEAD_BEEF, 1'b0);
        finish_load();
        check("t5r_n", wq.size(), 1);
        check_wq("t5r_w0", 0, {BASE, 32'hDEAD_BEEF});
        check("t5r_done", done, 1);

`ifdef IMEM_LOADER_CKSUM_EN
        // 6: checksum good and bad
        do_start(3'd1);
        send_word(32'h0102_0304, 1'b0);
        send_byte(8'h04);
        byte_valid = 1'b0;
        check("t6g_done", done, 1);
        check("t6g_err", err, 0);
        check("t6g_hold", cpu_hold, 0);
        do_start(3'd1);
        send_word(32'h0102_0304, 1'b0);
        send_byte(8'h05);
        byte_valid = 1'b0;
        check("t6b_done", done, 1);
        check("t6b_err", err, 1);
        check("t6b_hold", cpu_hold, 1);
        check("t6b_n", wq.size(), 1);
        check_wq("t6b_w0", 0, {BASE, 32'h0102_0304});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
